mix_columns_sched: RTL

MIX_COLUMNS_SCHED -- requirements
Module: mix_columns_sched

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/mix_columns_sched_if.sv | 29 ++
 rtl/mix_single_column.sv | 30 +++
 rtl/mix_columns_sched.sv | 96 +++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: GF(2^8) reduction constant, FSM state
// encodings, forward/inverse row coefficients and GF(2^8) helper functions.
package aes_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned COL_W  = 4 * BYTE_W;

  // Low byte of the reduction polynomial x^8 + x^4 + x^3 + x + 1 (0x11b).
  localparam logic [BYTE_W-1:0] RED_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Row-0 coefficients; coefficient k sits at [8k +: 8]. Row r uses the
  // coefficient at index (j - r) mod 4 for input row j.
  localparam logic [COL_W-1:0] FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
  localparam logic [COL_W-1:0] INV_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

  // Multiply by x in GF(2^8).
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? RED_POLY : 8'h00);
  endfunction

  // Shift-and-add GF(2^8) multiply; constant b prunes to a few XORs.
  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/mix_columns_sched_if.sv
// Handshake bundle for mix_columns_sched.
//   in_valid/in_ready/state_in/inv : input block channel
//   out_valid/out_ready/state_out  : result channel
//   busy                           : block in flight (RUN or DONE)
interface mix_columns_sched_if #(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned ARRAY_SIZE = 16
);
  localparam int unsigned STATE_W = WORD_SIZE * ARRAY_SIZE;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] state_in;
  logic               inv;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] state_out;
  logic               busy;

  modport master (
    output in_valid, state_in, inv, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, state_in, inv, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/mix_single_column.sv
// Combinational (Inv)MixColumns of one 32-bit column.
//   col_i : input column, row r at [8r +: 8]
//   inv_i : 0 forward, 1 inverse
//   col_o : output column, same layout
module mix_single_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  input  logic             inv_i,
  output logic [COL_W-1:0] col_o
);

  logic [COL_W-1:0] coef_c;

  // Circulant matrix product: each row rotates the row-0 coefficients.
  always_comb begin
    coef_c = inv_i ? INV_COEF : FWD_COEF;
    col_o  = '0;
    for (int r = 0; r < 4; r++) begin
      logic [BYTE_W-1:0] acc;
      acc = '0;
      for (int j = 0; j < 4; j++) begin
        acc = acc ^ gf_mul(col_i[BYTE_W*j +: BYTE_W],
                           coef_c[BYTE_W*((j + 4 - r) % 4) +: BYTE_W]);
      end
      col_o[BYTE_W*r +: BYTE_W] = acc;
    end
  end

endmodule

// File: rtl/mix_columns_sched.sv
// Column-serial AES (Inv)MixColumns over a full state using one shared column
// unit; one column per cycle, result 4 edges after acceptance.
//   clk : clock, rising edge
//   rst : synchronous active-low reset
//   bus : slave side of mix_columns_sched_if (in/out handshakes, busy)
module mix_columns_sched
  import aes_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned ARRAY_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mix_columns_sched_if.slave   bus
);

  localparam int unsigned STATE_W = WORD_SIZE * ARRAY_SIZE;

  state_e             state_q;
  logic [1:0]         col_q;
  logic [STATE_W-1:0] cap_q;
  logic               inv_q;
  logic [STATE_W-1:0] res_q;

  logic               in_ready_c;
  logic               accept_c;
  logic [COL_W-1:0]   col_in_c;
  logic [COL_W-1:0]   col_out_c;

  // Ready in IDLE, or in DONE when the result leaves on this same edge.
  assign in_ready_c = rst && ((state_q == IDLE) ||
                              ((state_q == DONE) && bus.out_ready));
  assign accept_c   = bus.in_valid && in_ready_c;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.state_out = res_q;

  // Gather captured column col_q.
  always_comb begin
    col_in_c = '0;
    for (int r = 0; r < 4; r++) begin
      col_in_c[BYTE_W*r +: BYTE_W] = cap_q[COL_W*r + BYTE_W*int'(col_q) +: BYTE_W];
    end
  end

  mix_single_column u_col (
    .col_i (col_in_c),
    .inv_i (inv_q),
    .col_o (col_out_c)
  );

  // Scheduler FSM, capture registers and column write-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      cap_q   <= '0;
      inv_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            cap_q   <= bus.state_in;
            inv_q   <= bus.inv;
            col_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int r = 0; r < 4; r++) begin
            res_q[COL_W*r + BYTE_W*int'(col_q) +: BYTE_W] <= col_out_c[BYTE_W*r +: BYTE_W];
          end
          col_q <= 2'(col_q + 2'd1);
          if (col_q == 2'd3) state_q <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            if (accept_c) begin
              cap_q   <= bus.state_in;
              inv_q   <= bus.inv;
              col_q   <= '0;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
